// File: rtl/afifo_flags_pkg.sv
// afifo_flags_pkg: constants and Gray/binary helpers shared by the async FIFO.
package afifo_flags_pkg;

  // Flops in every clock-domain crossing chain (pointers and reset release).
  localparam int SYNC_STAGES = 2;

  // Widest pointer supported: ADDRESS_WIDTH up to 12 plus the wrap bit.
  localparam int PTR_MAX_W = 13;

  typedef logic [PTR_MAX_W-1:0] ptr_t;

  // Callers zero-extend narrower pointers into ptr_t and truncate the result
  // back; leading zeros do not disturb the low bits of either conversion.
  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/afifo_flags_gray_ptr_sync.sv
// gray_ptr_sync: multi-flop synchroniser for a Gray-coded pointer entering
// the clock domain of clk_i. Only one bit changes per source update, so the
// sampled value is always either the old or the new pointer.
module gray_ptr_sync
  import afifo_flags_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] gray_o
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

  // Shift the foreign pointer through the synchroniser chain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], gray_i};
  end

  assign gray_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/afifo_flags.sv
// afifo_flags: dual-clock FIFO with registered full/empty, almost flags,
// per-side fill levels and sticky overflow/underflow. Binary pointers live
// in their own domain; only their Gray copies cross.
module afifo_flags
  import afifo_flags_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int AFULL_LEVEL   = 2**ADDRESS_WIDTH - 2,
  parameter int AEMPTY_LEVEL  = 2,
  parameter int SHOW_AHEAD    = 0
) (
  input  logic                   rdclk,
  input  logic                   PresetFull,
  input  logic                   wrclk,
  input  logic [DATA_WIDTH-1:0]  data,
  input  logic                   wrreq,
  output logic                   wrfull,
  output logic                   wralmostfull,
  output logic [ADDRESS_WIDTH:0] wrusedw,
  output logic                   overflow,
  output logic [DATA_WIDTH-1:0]  q,
  input  logic                   rdreq,
  output logic                   rdempty,
  output logic                   rdalmostempty,
  output logic [ADDRESS_WIDTH:0] rdusedw,
  output logic                   underflow,
  input  logic                   clr_flags
);

  localparam int PW    = ADDRESS_WIDTH + 1;
  localparam int DEPTH = 2**ADDRESS_WIDTH;
  localparam logic [PW-1:0] AFULL_L  = PW'(AFULL_LEVEL);
  localparam logic [PW-1:0] AEMPTY_L = PW'(AEMPTY_LEVEL);

  // ---------------------------------------------------------------- resets
  logic [SYNC_STAGES-1:0] wrst_sync_q, rrst_sync_q;
  logic                   wrst, rrst;

  // Write-domain reset: asserts with PresetFull, releases after two wrclk edges.
  always_ff @(posedge wrclk or posedge PresetFull) begin
    if (PresetFull) wrst_sync_q <= '1;
    else            wrst_sync_q <= {wrst_sync_q[SYNC_STAGES-2:0], 1'b0};
  end

  // Read-domain reset: asserts with PresetFull, releases after two rdclk edges.
  always_ff @(posedge rdclk or posedge PresetFull) begin
    if (PresetFull) rrst_sync_q <= '1;
    else            rrst_sync_q <= {rrst_sync_q[SYNC_STAGES-2:0], 1'b0};
  end

  assign wrst = wrst_sync_q[SYNC_STAGES-1];
  assign rrst = rrst_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------- storage
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ------------------------------------------------------------ write side
  logic [PW-1:0] wptr_bin_q, wptr_gray_q, wbin_d, wgray_d;
  logic [PW-1:0] rq2_gray, rbin_w;
  logic [PW-1:0] wrusedw_q, wrusedw_d;
  logic          wrfull_q, wrfull_d, wralmostfull_q, wralmostfull_d;
  logic          overflow_q, overflow_d, wr_en;
  logic [SYNC_STAGES:0] clr_sync_q;
  logic          clr_wr;

  // ------------------------------------------------------------- read side
  logic [PW-1:0] rptr_bin_q, rptr_gray_q, rbin_d, rgray_d;
  logic [PW-1:0] wq2_gray, wbin_r;
  logic [PW-1:0] rdusedw_q, rdusedw_d;
  logic          rdempty_q, rdempty_d, rdalmostempty_q, rdalmostempty_d;
  logic          underflow_q, underflow_d, rd_en;
  logic          clr_tgl_q;
  logic [DATA_WIDTH-1:0] q_q;

  gray_ptr_sync #(.WIDTH(PW)) u_rptr_to_wr (
    .clk_i  (wrclk),
    .rst_i  (wrst),
    .gray_i (rptr_gray_q),
    .gray_o (rq2_gray)
  );

  gray_ptr_sync #(.WIDTH(PW)) u_wptr_to_rd (
    .clk_i  (rdclk),
    .rst_i  (rrst),
    .gray_i (wptr_gray_q),
    .gray_o (wq2_gray)
  );

  // Write-side next state: flags are computed from the post-write pointer so
  // they are exact for this domain and only pessimistic about the far side.
  always_comb begin
    wr_en          = wrreq & ~wrfull_q & ~wrst;
    wbin_d         = wptr_bin_q + PW'(wr_en);
    wgray_d        = PW'(bin2gray(ptr_t'(wbin_d)));
    rbin_w         = PW'(gray2bin(ptr_t'(rq2_gray)));
    // Full: write pointer is one lap ahead, i.e. the top two Gray bits differ.
    wrfull_d       = (wgray_d == {~rq2_gray[PW-1:PW-2], rq2_gray[PW-3:0]});
    wrusedw_d      = wbin_d - rbin_w;
    wralmostfull_d = (wrusedw_d >= AFULL_L);
    overflow_d     = (wrreq & wrfull_q) | (overflow_q & ~clr_wr);
  end

  // Write-side state registers.
  always_ff @(posedge wrclk or posedge wrst) begin
    if (wrst) begin
      wptr_bin_q     <= '0;
      wptr_gray_q    <= '0;
      wrfull_q       <= 1'b0;
      wralmostfull_q <= 1'b0;
      wrusedw_q      <= '0;
      overflow_q     <= 1'b0;
    end else begin
      wptr_bin_q     <= wbin_d;
      wptr_gray_q    <= wgray_d;
      wrfull_q       <= wrfull_d;
      wralmostfull_q <= wralmostfull_d;
      wrusedw_q      <= wrusedw_d;
      overflow_q     <= overflow_d;
    end
  end

  // clr_flags arrives as a read-domain toggle; a change seen after the
  // synchroniser becomes a one-wrclk clear strobe for overflow.
  always_ff @(posedge wrclk or posedge wrst) begin
    if (wrst) clr_sync_q <= '0;
    else      clr_sync_q <= {clr_sync_q[SYNC_STAGES-1:0], clr_tgl_q};
  end

  assign clr_wr = clr_sync_q[SYNC_STAGES] ^ clr_sync_q[SYNC_STAGES-1];

  // Write port of the dual-port RAM; contents survive reset.
  always_ff @(posedge wrclk) begin
    if (wr_en) mem[wptr_bin_q[ADDRESS_WIDTH-1:0]] <= data;
  end

  // Read-side next state, mirror image of the write side.
  always_comb begin
    rd_en           = rdreq & ~rdempty_q;
    rbin_d          = rptr_bin_q + PW'(rd_en);
    rgray_d         = PW'(bin2gray(ptr_t'(rbin_d)));
    wbin_r          = PW'(gray2bin(ptr_t'(wq2_gray)));
    rdempty_d       = (rgray_d == wq2_gray);
    rdusedw_d       = wbin_r - rbin_d;
    rdalmostempty_d = (rdusedw_d <= AEMPTY_L);
    // A read attempt on empty in the same cycle as clr_flags keeps the flag.
    underflow_d     = (rdreq & rdempty_q) | (underflow_q & ~clr_flags);
  end

  // Read-side state registers.
  always_ff @(posedge rdclk or posedge rrst) begin
    if (rrst) begin
      rptr_bin_q      <= '0;
      rptr_gray_q     <= '0;
      rdempty_q       <= 1'b1;
      rdalmostempty_q <= 1'b1;
      rdusedw_q       <= '0;
      underflow_q     <= 1'b0;
      clr_tgl_q       <= 1'b0;
    end else begin
      rptr_bin_q      <= rbin_d;
      rptr_gray_q     <= rgray_d;
      rdempty_q       <= rdempty_d;
      rdalmostempty_q <= rdalmostempty_d;
      rdusedw_q       <= rdusedw_d;
      underflow_q     <= underflow_d;
      clr_tgl_q       <= clr_tgl_q ^ clr_flags;
    end
  end

  // Read port of the dual-port RAM.
  if (SHOW_AHEAD != 0) begin : g_show_ahead
    // Prefetch the word at the next read address every cycle so the head is
    // already on q when rdempty falls and a read advances with no bubble.
    always_ff @(posedge rdclk or posedge rrst) begin
      if (rrst) q_q <= '0;
      else      q_q <= mem[rbin_d[ADDRESS_WIDTH-1:0]];
    end
  end else begin : g_registered
    // Classic mode: q loads on the accepting edge and holds otherwise.
    always_ff @(posedge rdclk or posedge rrst) begin
      if (rrst)       q_q <= '0;
      else if (rd_en) q_q <= mem[rptr_bin_q[ADDRESS_WIDTH-1:0]];
    end
  end

  assign wrfull        = wrfull_q;
  assign wralmostfull  = wralmostfull_q;
  assign wrusedw       = wrusedw_q;
  assign overflow      = overflow_q;
  assign q             = q_q;
  assign rdempty       = rdempty_q;
  assign rdalmostempty = rdalmostempty_q;
  assign rdusedw       = rdusedw_q;
  assign underflow     = underflow_q;

endmodule

// File: tb/tb_afifo_flags.sv
// tb_afifo_flags: directed bench for afifo_flags. Two instances share the
// stimulus (registered read and show-ahead read); a queue model tracks the
// words each one holds and the read-domain sticky flag.
`timescale 1ns/1ps
module tb_afifo_flags;

  localparam int DEPTH    = 16;
  localparam int N_STREAM = 10000;

  logic       rdclk = 1'b0, wrclk = 1'b0, PresetFull = 1'b1;
  logic [7:0] data = '0;
  logic       wrreq = 1'b0, rdreq = 1'b0, clr_flags = 1'b0;
  realtime    rd_half = 13.5;

  logic       wrfull_r, wralmostfull_r, overflow_r, rdempty_r, rdalmostempty_r, underflow_r;
  logic [4:0] wrusedw_r, rdusedw_r;
  logic [7:0] q_r;
  logic       wrfull_f, wralmostfull_f, overflow_f, rdempty_f, rdalmostempty_f, underflow_f;
  logic [4:0] wrusedw_f, rdusedw_f;
  logic [7:0] q_f;

  afifo_flags #(.SHOW_AHEAD(0)) u_dut (
    .rdclk(rdclk), .PresetFull(PresetFull), .wrclk(wrclk), .data(data), .wrreq(wrreq),
    .wrfull(wrfull_r), .wralmostfull(wralmostfull_r), .wrusedw(wrusedw_r), .overflow(overflow_r),
    .q(q_r), .rdreq(rdreq), .rdempty(rdempty_r), .rdalmostempty(rdalmostempty_r),
    .rdusedw(rdusedw_r), .underflow(underflow_r), .clr_flags(clr_flags)
  );

  afifo_flags #(.SHOW_AHEAD(1)) u_fwft (
    .rdclk(rdclk), .PresetFull(PresetFull), .wrclk(wrclk), .data(data), .wrreq(wrreq),
    .wrfull(wrfull_f), .wralmostfull(wralmostfull_f), .wrusedw(wrusedw_f), .overflow(overflow_f),
    .q(q_f), .rdreq(rdreq), .rdempty(rdempty_f), .rdalmostempty(rdalmostempty_f),
    .rdusedw(rdusedw_f), .underflow(underflow_f), .clr_flags(clr_flags)
  );

  always #5 wrclk = ~wrclk;
  always #(rd_half) rdclk = ~rdclk;

  int vecs = 0, errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [7:0] mq_r[$], mq_f[$];
  logic [7:0] exp_q_r = '0;
  logic       exp_uf  = 1'b0;
  int         wr_acc = 0, rd_acc = 0;

  // Writes accepted by each instance join its queue.
  always @(posedge wrclk) begin
    if (!PresetFull && wrreq) begin
      if (!wrfull_r) begin mq_r.push_back(data); wr_acc++; end
      if (!wrfull_f) mq_f.push_back(data);
    end
  end

  // Reads accepted pop the queue; a read on empty is a sticky underflow.
  always @(posedge rdclk) begin
    if (!PresetFull) begin
      if (rdreq && rdempty_r) exp_uf = 1'b1;
      else if (clr_flags)     exp_uf = 1'b0;
      if (rdreq && !rdempty_r) begin
        chk("rd_accept_model_nonempty", 32'(mq_r.size() > 0), 32'd1);
        if (mq_r.size() > 0) begin exp_q_r = mq_r.pop_front(); rd_acc++; end
      end
      if (rdreq && !rdempty_f && mq_f.size() > 0) void'(mq_f.pop_front());
    end
  end

  // Read-domain checks every rdclk cycle.
  always @(negedge rdclk) begin
    if (!PresetFull) begin
      chk("q", 32'(q_r), 32'(exp_q_r));
      chk("underflow", 32'(underflow_r), 32'(exp_uf));
      chk("rdusedw_le_fill", 32'(int'(rdusedw_r) <= mq_r.size()), 32'd1);
      if (!rdempty_r) chk("rdempty_no_false_clear", 32'(mq_r.size() > 0), 32'd1);
      if (!rdempty_f) begin
        chk("fwft_nonempty", 32'(mq_f.size() > 0), 32'd1);
        if (mq_f.size() > 0) chk("fwft_head", 32'(q_f), 32'(mq_f[0]));
      end
    end
  end

  // Write-domain checks every wrclk cycle.
  always @(negedge wrclk) begin
    if (!PresetFull) begin
      chk("wrusedw_ge_fill", 32'(int'(wrusedw_r) >= mq_r.size()), 32'd1);
      chk("wrusedw_le_depth", 32'(int'(wrusedw_r) <= DEPTH), 32'd1);
      if (!wrfull_r) chk("wrfull_no_false_clear", 32'(mq_r.size() < DEPTH), 32'd1);
    end
  end

  initial begin
    #2ms;
    errs++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ stimulus
  initial begin
    int  n;
    bit  got;
    int  base_w, base_r;

    // Reset state.
    repeat (3) @(posedge wrclk);
    #1;
    chk("rst_rdempty", 32'(rdempty_r), 32'd1);
    chk("rst_rdalmostempty", 32'(rdalmostempty_r), 32'd1);
    chk("rst_wrfull", 32'(wrfull_r), 32'd0);
    chk("rst_wralmostfull", 32'(wralmostfull_r), 32'd0);
    chk("rst_wrusedw", 32'(wrusedw_r), 32'd0);
    chk("rst_rdusedw", 32'(rdusedw_r), 32'd0);
    chk("rst_overflow", 32'(overflow_r), 32'd0);
    chk("rst_underflow", 32'(underflow_r), 32'd0);
    chk("rst_q", 32'(q_r), 32'd0);
    @(negedge wrclk); PresetFull = 1'b0;
    repeat (4) @(negedge wrclk);
    repeat (4) @(negedge rdclk);

    // Fill: 16 words 0x00..0x0F, then one write too many.
    for (int i = 0; i < 16; i++) begin
      @(negedge wrclk); wrreq = 1'b1; data = 8'(i);
      @(negedge wrclk); wrreq = 1'b0;
      chk("fill_wrusedw", 32'(wrusedw_r), 32'(i + 1));
      chk("fill_wralmostfull", 32'(wralmostfull_r), 32'(i + 1 >= 14));
      chk("fill_wrfull", 32'(wrfull_r), 32'(i + 1 == 16));
    end
    @(negedge wrclk); wrreq = 1'b1; data = 8'hEE;
    @(negedge wrclk); wrreq = 1'b0;
    chk("ovf_set", 32'(overflow_r), 32'd1);
    chk("ovf_wrusedw", 32'(wrusedw_r), 32'd16);
    chk("ovf_wrfull", 32'(wrfull_r), 32'd1);
    repeat (4) @(negedge rdclk);
    chk("full_rdusedw", 32'(rdusedw_r), 32'd16);
    chk("full_rdempty", 32'(rdempty_r), 32'd0);
    chk("full_rdalmostempty", 32'(rdalmostempty_r), 32'd0);

    // Drain in registered mode.
    for (int i = 0; i < 16; i++) begin
      @(negedge rdclk); rdreq = 1'b1;
      @(negedge rdclk); rdreq = 1'b0;
      chk("drain_q", 32'(q_r), 32'(i));
      chk("drain_rdusedw", 32'(rdusedw_r), 32'(15 - i));
      chk("drain_rdalmostempty", 32'(rdalmostempty_r), 32'(15 - i <= 2));
      chk("drain_rdempty", 32'(rdempty_r), 32'(i == 15));
    end
    chk("ovf_sticky", 32'(overflow_r), 32'd1);

    // Underflow, clear-vs-set priority, clear.
    @(negedge rdclk); rdreq = 1'b1;
    @(negedge rdclk); rdreq = 1'b0;
    chk("uf_set", 32'(underflow_r), 32'd1);
    chk("uf_q_hold", 32'(q_r), 32'h0F);
    @(negedge rdclk); rdreq = 1'b1; clr_flags = 1'b1;
    @(negedge rdclk); rdreq = 1'b0; clr_flags = 1'b0;
    chk("uf_set_wins", 32'(underflow_r), 32'd1);
    @(negedge rdclk); clr_flags = 1'b1;
    @(negedge rdclk); clr_flags = 1'b0;
    chk("uf_cleared", 32'(underflow_r), 32'd0);
    repeat (6) @(negedge wrclk);
    chk("ovf_cleared", 32'(overflow_r), 32'd0);
    chk("empty_wrusedw", 32'(wrusedw_r), 32'd0);
    chk("empty_wrfull", 32'(wrfull_r), 32'd0);
    chk("empty_wralmostfull", 32'(wralmostfull_r), 32'd0);

    // Single word with rdclk at three times wrclk.
    rd_half = 5.0 / 3.0;
    repeat (10) @(negedge rdclk);
    @(negedge wrclk); data = 8'hA5; wrreq = 1'b1;
    @(posedge wrclk);
    fork begin #1; wrreq = 1'b0; end join_none
    n = 0; got = 1'b0;
    while (n < 6 && !got) begin
      @(posedge rdclk); n++;
      @(negedge rdclk);
      if (!rdempty_r) got = 1'b1;
    end
    chk("empty_latency_le3", 32'(got && n <= 3), 32'd1);
    chk("fwft_rdempty", 32'(rdempty_f), 32'd0);
    chk("fwft_q_a5", 32'(q_f), 32'hA5);
    @(negedge rdclk); rdreq = 1'b1;
    @(negedge rdclk); rdreq = 1'b0;
    chk("a5_q", 32'(q_r), 32'hA5);
    chk("a5_fwft_empty", 32'(rdempty_f), 32'd1);

    // Reset with 9 words held.
    rd_half = 13.5;
    repeat (3) @(negedge rdclk);
    for (int i = 0; i < 9; i++) begin
      @(negedge wrclk); wrreq = 1'b1; data = 8'(8'h30 + i);
    end
    @(negedge wrclk); wrreq = 1'b0;
    repeat (4) @(negedge rdclk);
    chk("pre_rst_rdusedw", 32'(rdusedw_r), 32'd9);
    @(negedge wrclk);
    PresetFull = 1'b1;
    mq_r.delete(); mq_f.delete(); exp_q_r = '0; exp_uf = 1'b0;
    #1;
    chk("midrst_rdempty", 32'(rdempty_r), 32'd1);
    chk("midrst_wrfull", 32'(wrfull_r), 32'd0);
    chk("midrst_wrusedw", 32'(wrusedw_r), 32'd0);
    chk("midrst_rdusedw", 32'(rdusedw_r), 32'd0);
    chk("midrst_fwft_rdempty", 32'(rdempty_f), 32'd1);
    repeat (3) @(negedge wrclk);
    PresetFull = 1'b0;
    repeat (4) @(negedge wrclk);
    repeat (4) @(negedge rdclk);
    @(negedge wrclk); wrreq = 1'b1; data = 8'h51;
    @(negedge wrclk); data = 8'h52;
    @(negedge wrclk); wrreq = 1'b0;
    repeat (4) @(negedge rdclk);
    chk("post_rst_rdusedw", 32'(rdusedw_r), 32'd2);
    @(negedge rdclk); rdreq = 1'b1;
    @(negedge rdclk);
    chk("post_rst_q0", 32'(q_r), 32'h51);
    @(negedge rdclk); rdreq = 1'b0;
    chk("post_rst_q1", 32'(q_r), 32'h52);
    chk("post_rst_empty", 32'(rdempty_r), 32'd1);

    // Streaming: 100 MHz writer, 37 MHz reader, both with periodic gaps.
    base_w = wr_acc; base_r = rd_acc;
    fork
      begin
        int cyc;
        cyc = 0;
        while (wr_acc - base_w < N_STREAM && cyc < 40000) begin
          @(negedge wrclk);
          wrreq = (wr_acc - base_w < N_STREAM) && (cyc % 7 != 3);
          data  = 8'((wr_acc - base_w) * 13 + 5);
          cyc++;
        end
        wrreq = 1'b0;
      end
      begin
        int rcyc;
        rcyc = 0;
        while (rd_acc - base_r < N_STREAM && rcyc < 12500) begin
          @(negedge rdclk);
          rdreq = (rd_acc - base_r < N_STREAM) && (rcyc % 11 != 5);
          rcyc++;
        end
        rdreq = 1'b0;
      end
    join
    chk("stream_writes", 32'(wr_acc - base_w), 32'(N_STREAM));
    chk("stream_reads", 32'(rd_acc - base_r), 32'(N_STREAM));
    repeat (4) @(negedge rdclk);
    chk("stream_end_rdempty", 32'(rdempty_r), 32'd1);
    chk("stream_end_rdusedw", 32'(rdusedw_r), 32'd0);
    repeat (4) @(negedge wrclk);
    chk("stream_end_wrusedw", 32'(wrusedw_r), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/afifo_flags.md
AFIFO_FLAGS -- requirements
Module: afifo_flags

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data word width in bits.
REQ-002 Parameter ADDRESS_WIDTH, default 4, depth = 2**ADDRESS_WIDTH words; legal range 2..12.
REQ-003 Parameter AFULL_LEVEL, default 2**ADDRESS_WIDTH-2, write-side fill level at or above which wralmostfull asserts.
REQ-004 Parameter AEMPTY_LEVEL, default 2, read-side fill level at or below which rdalmostempty asserts.
REQ-005 Parameter SHOW_AHEAD, default 0, 1 selects first-word-fall-through read mode.
REQ-006 rdclk  in  1  read-domain clock; primary clock of the block.
REQ-007 PresetFull  in  1  reset, asynchronous, active-high; clears both domains.
REQ-008 wrclk  in  1  write-domain clock, asynchronous to rdclk.
REQ-009 data  in  DATA_WIDTH  write data; wrreq  in  1  write request; wrfull  out  1  full flag.
REQ-010 wralmostfull  out  1; wrusedw  out  ADDRESS_WIDTH+1  write-side fill level; overflow  out  1  sticky.
REQ-011 q  out  DATA_WIDTH  read data; rdreq  in  1  read request; rdempty  out  1  empty flag.
REQ-012 rdalmostempty  out  1; rdusedw  out  ADDRESS_WIDTH+1  read-side fill level; underflow  out  1  sticky.
REQ-013 clr_flags  in  1  rdclk-domain pulse clearing underflow, and via synchroniser, overflow.

Function
REQ-014 Pointers SHALL be ADDRESS_WIDTH+1-bit binary counters with Gray copies registered in their own domain; only Gray values cross domains.
REQ-015 Each crossing Gray pointer SHALL pass a 2-flop synchroniser in the destination domain.
REQ-016 Write accepted iff wrreq & !wrfull on wrclk rising edge; read accepted iff rdreq & !rdempty on rdclk rising edge.
REQ-017 wrfull SHALL be registered: 1 when next write Gray pointer equals synced read Gray pointer with two MSBs inverted.
REQ-018 rdempty SHALL be registered: 1 when next read Gray pointer equals synced write Gray pointer.
REQ-019 wrusedw = wptr_bin - synced rptr converted to binary, modulo 2**(ADDRESS_WIDTH+1); rdusedw symmetric; both registered, range 0..depth.
REQ-020 wralmostfull = (wrusedw_next >= AFULL_LEVEL); rdalmostempty = (rdusedw_next <= AEMPTY_LEVEL); registered.
REQ-021 SHOW_AHEAD=0: q registered, updated on the rdclk edge accepting the read, holds otherwise.
REQ-022 SHOW_AHEAD=1: q SHALL present the head word in the same cycle rdempty=0; accepted read advances to next word with zero-cycle bubble.
REQ-023 Write-to-read latency: rdempty deasserts no later than the 3rd rdclk rising edge after the accepting wrclk edge; read-to-write free-slot latency symmetric (3 wrclk edges).
REQ-024 wrreq while wrfull SHALL be dropped, pointer and memory unchanged, overflow set; rdreq while rdempty SHALL be ignored, underflow set.
REQ-025 Pointer wrap past depth SHALL be seamless; full/empty remain exact across MSB toggle.
REQ-026 Simultaneous write and read in their domains SHALL not corrupt usedw beyond synchroniser lag; flags stay conservative (full/empty may linger, never false-clear).
REQ-027 clr_flags and a same-cycle underflow event: set wins.

Reset
REQ-028 PresetFull high SHALL asynchronously force: pointers 0, synchronisers 0, rdempty=1, rdalmostempty=1, wrfull=0, wralmostfull=0, usedw=0, overflow=0, underflow=0, q=0.
REQ-029 Reset deassertion SHALL be synchronised separately into rdclk and wrclk domains (2-flop release); reset mid-transfer discards all contents.
REQ-030 Memory array contents SHALL not be reset.

Structure
REQ-031 Shared package holds Gray/binary conversion functions and synchroniser stage count constant (2).
REQ-032 One sub-module gray_ptr_sync (parametrised width, 2-flop Gray synchroniser with async reset), instantiated twice.
REQ-033 Memory SHALL be inferred dual-port RAM: write port on wrclk, read port on rdclk.

Verification
REQ-034 Reset, write 16 words 0x00..0x0F (depth 16) -> wrfull=1 after 16th, wrusedw=16, wralmostfull from 14th write; 17th write -> overflow=1, data unchanged.
REQ-035 Read all 16 with SHOW_AHEAD=0 -> q=0x00..0x0F each one cycle after accept, rdempty=1 after last; extra rdreq -> underflow=1, clr_flags clears it.
REQ-036 Single write 0xA5 to empty FIFO, rdclk 3x wrclk -> rdempty deasserts within 3 rdclk edges; SHOW_AHEAD=1 shows q=0xA5 same cycle.
REQ-037 Continuous write/read, 100 MHz wr / 37 MHz rd, 10000 words -> all data in order, no false flag clears, pointers wrap 600+ times.
REQ-038 PresetFull asserted with 9 words stored -> rdempty=1, wrfull=0, usedw=0 immediately; post-reset read returns only new data.
